// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter and its round-robin picker.
package mem_arb_pkg;
    localparam int NUM_REQ_DEF     = 3;
    localparam int OWNER_W         = 2;
    localparam int TIMEOUT_CYC_DEF = 15;
    localparam int TMO_CNT_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_OWNED = 2'd2,
        S_TURN  = 2'd3
    } arb_state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) ();
    logic [NUM_REQ-1:0] req;
    logic               bus_busy;
    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] owner_id;
    logic               bus_idle;
    logic               timeout_err;

    modport master (
        input  req, bus_busy,
        output grant, owner_id, bus_idle, timeout_err
    );

    modport slave (
        output req, bus_busy,
        input  grant, owner_id, bus_idle, timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [OWNER_W-1:0] id_o,
    output logic               any_o
);
    function automatic int wrap_idx(input logic [OWNER_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s;
    endfunction

    // Scan farthest offset first so the candidate nearest rr_ptr overwrites the rest.
    always_comb begin
        pick_o = '0;
        id_o   = '0;
        any_o  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[wrap_idx(rr_ptr_i, i)]) begin
                pick_o                        = '0;
                pick_o[wrap_idx(rr_ptr_i, i)] = 1'b1;
                id_o                          = OWNER_W'(wrap_idx(rr_ptr_i, i));
                any_o                         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin memory bus arbiter: IDLE -> GRANT -> OWNED -> TURN with registered outputs.
// Define MEM_ARB_TIMEOUT_EN to revoke a grant that is never taken within TIMEOUT_CYC cycles.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("mem_bus_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic               bus_idle_q, bus_idle_d;

    logic [NUM_REQ-1:0] pick;
    logic [OWNER_W-1:0] pick_id;
    logic               pick_any;
    logic               owner_req;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 tmo_hit;
`endif

    function automatic logic [OWNER_W-1:0] next_id(input logic [OWNER_W-1:0] id);
        return (id == OWNER_W'(NUM_REQ - 1)) ? '0 : id + OWNER_W'(1);
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick),
        .id_o     (pick_id),
        .any_o    (pick_any)
    );

    assign owner_req = |(bus.req & grant_q);

`ifdef MEM_ARB_TIMEOUT_EN
    assign tmo_hit = (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            // A busy bus in IDLE belongs to nobody we granted; wait for it to clear.
            S_IDLE: begin
                if (!bus.bus_busy && pick_any) begin
                    grant_d = pick;
                    owner_d = pick_id;
                    state_d = S_GRANT;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_GRANT: begin
                if (bus.bus_busy) begin
                    state_d = S_OWNED;
                end else if (!owner_req) begin
                    grant_d = '0;
                    state_d = S_TURN;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    grant_d       = '0;
                    rr_ptr_d      = next_id(owner_q);
                    timeout_err_d = 1'b1;
                    state_d       = S_TURN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
`endif
            end
            S_OWNED: begin
                if (!bus.bus_busy) begin
                    grant_d  = '0;
                    rr_ptr_d = next_id(owner_q);
                    state_d  = S_TURN;
                end
            end
            S_TURN: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
        bus_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            bus_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            bus_idle_q <= bus_idle_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.owner_id = owner_q;
    assign bus.bus_idle = bus_idle_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed vectors queue expected outputs, a monitor compares.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = TIMEOUT_CYC_DEF;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NUM_REQ(3)) bus ();

    mem_bus_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        int unsigned due;
        logic [2:0]  grant;
        logic [1:0]  owner;
        logic        idle;
        logic        tmo;
    } exp_t;

    exp_t        sb_q[$];
    string       nm_q[$];
    int unsigned cyc   = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [2:0]  prev_grant = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [2:0] g, input logic [1:0] o, input logic i, input logic t,
                         input logic [2:0] eg, input logic [1:0] eo, input logic ei, input logic et);
        n_vec++;
        if ({g, o, i, t} !== {eg, eo, ei, et}) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got grant=%b owner=%0d idle=%b tmo=%b, want grant=%b owner=%0d idle=%b tmo=%b",
                     nm, cyc, g, o, i, t, eg, eo, ei, et);
        end
    endtask

    // Drive one cycle of inputs; the expected outputs appear after the next rising edge.
    task automatic vec(input logic [2:0] r, input logic b,
                       input logic [2:0] eg, input logic [1:0] eo, input logic ei, input logic et,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        bus.req      = r;
        bus.bus_busy = b;
        e.due   = cyc + 1;
        e.grant = eg;
        e.owner = eo;
        e.idle  = ei;
        e.tmo   = et;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    always @(negedge clk) begin : mon_p
        exp_t  e;
        string nm;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            if (e.due < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d not checked in time (now %0d)", nm, e.due, cyc);
            end else begin
                check(nm, bus.grant, bus.owner_id, bus.bus_idle, bus.timeout_err,
                      e.grant, e.owner, e.idle, e.tmo);
            end
        end
        n_vec++;
        if (!$onehot0(bus.grant) || (prev_grant != 3'b000 && bus.grant != 3'b000 && bus.grant != prev_grant)) begin
            n_bad++;
            $display("FAIL grant_exclusive @cyc %0d: got grant=%b after %b, want one-hot with a zero cycle between owners",
                     cyc, bus.grant, prev_grant);
        end
        prev_grant = bus.grant;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.req      = 3'b000;
        bus.bus_busy = 1'b0;
        #2 reset = 1'b0;
        #2 check("reset_state", bus.grant, bus.owner_id, bus.bus_idle, bus.timeout_err, 3'b000, 2'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // All three requesting, each owner busy two cycles.
        vec(3'b111, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rr_grant0");
        vec(3'b111, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0, "rr_own0_a");
        vec(3'b111, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0, "rr_own0_b");
        vec(3'b111, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "rr_turn0");
        vec(3'b111, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "rr_idle0");
        vec(3'b111, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "rr_grant1");
        vec(3'b111, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "rr_own1_a");
        vec(3'b111, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "rr_own1_b");
        vec(3'b111, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, "rr_turn1");
        vec(3'b111, 1'b0, 3'b000, 2'd1, 1'b1, 1'b0, "rr_idle1");
        vec(3'b111, 1'b0, 3'b100, 2'd2, 1'b0, 1'b0, "rr_grant2");
        vec(3'b111, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, "rr_own2_a");
        vec(3'b111, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, "rr_own2_b");
        vec(3'b111, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, "rr_turn2");
        vec(3'b111, 1'b0, 3'b000, 2'd2, 1'b1, 1'b0, "rr_idle2");
        vec(3'b101, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "wrap_after_owner2");
        vec(3'b101, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0, "wrap_owned");
        vec(3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "wrap_turn");
        vec(3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "wrap_idle");

        // Single requester timeline; busy in IDLE must not produce a grant.
        vec(3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "idle_no_req");
        vec(3'b000, 1'b1, 3'b000, 2'd0, 1'b1, 1'b0, "busy_in_idle_ignored");
        vec(3'b010, 1'b1, 3'b000, 2'd0, 1'b1, 1'b0, "busy_blocks_grant");
        vec(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "single_grant1");
        vec(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "grant_holds");
        vec(3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "to_owned");
        for (int k = 0; k < 3; k++) vec(3'b000, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "owned_hold");
        vec(3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, "release_turn");
        vec(3'b000, 1'b0, 3'b000, 2'd1, 1'b1, 1'b0, "idle_after_turn");

        // rr_ptr is 2 here: bit 2 clear, so the pick wraps to 0; then 0 withdraws.
        vec(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "wrap_pick0");
        vec(3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "withdraw");
        vec(3'b110, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "withdraw_idle");
        vec(3'b110, 1'b0, 3'b100, 2'd2, 1'b0, 1'b0, "rr_kept_after_withdraw");
        vec(3'b110, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, "owned2");
        vec(3'b010, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, "turn2_held_req1");
        vec(3'b010, 1'b0, 3'b000, 2'd2, 1'b1, 1'b0, "idle_held_req1");
        vec(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "held_req1_served");
        vec(3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "owned_before_reset");

        // Asynchronous reset while OWNED.
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check("async_reset_drop", bus.grant, bus.owner_id, bus.bus_idle, bus.timeout_err, 3'b000, 2'd0, 1'b1, 1'b0);
        bus.req      = 3'b000;
        bus.bus_busy = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        vec(3'b000, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "no_turn_after_reset");
        vec(3'b100, 1'b0, 3'b100, 2'd2, 1'b0, 1'b0, "post_reset_grant");
        vec(3'b100, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, "post_reset_owned");
        vec(3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, "post_reset_turn");
        vec(3'b000, 1'b0, 3'b000, 2'd2, 1'b1, 1'b0, "post_reset_idle");

        // Grant that is never taken.
        vec(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "untaken_grant0");
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) vec(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "tmo_wait");
        vec(3'b011, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, "tmo_fire");
        vec(3'b011, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "tmo_single_pulse");
        vec(3'b011, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "req1_served");
`else
        for (int k = 0; k < 20; k++) vec(3'b011, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "grant_waits");
        vec(3'b011, 1'b1, 3'b001, 2'd0, 1'b0, 1'b0, "owned_late");
        vec(3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "turn_after_late");
        vec(3'b010, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "idle_after_late");
        vec(3'b010, 1'b0, 3'b010, 2'd1, 1'b0, 1'b0, "req1_served");
`endif
        vec(3'b010, 1'b1, 3'b010, 2'd1, 1'b0, 1'b0, "final_owned");
        vec(3'b000, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, "final_turn");
        vec(3'b000, 1'b0, 3'b000, 2'd1, 1'b1, 1'b0, "final_idle");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
